// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, add/sub FSM states and flag bit positions.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit combinational ripple adder; also exposes the carry into its MSB for overflow detection.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout  = carry[SLICE];
  assign c_msb = carry[SLICE-1];

endmodule

// File: rtl/addsub_serial.sv
// Slice-serial add/subtract with Z/N/C/V flags and start/busy/done handshake.
// Define ADDSUB_SERIAL_SAT_EN to clamp the result to the signed limit on overflow.
module addsub_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             use_cin,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, res_reg;
  logic [WIDTH-1:0] acc_next, res_next;
  logic             carry_reg, a_msb_reg, done_reg;
  logic [3:0]       flags_reg;

  logic             accept, last;
  logic [SLICE-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, cmsb_sl, v_final;

  assign accept = (state_reg == ST_IDLE) && start;
  assign last   = (state_reg == ST_RUN) && (cnt_reg == CW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_IDLE;
      default:            state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ST_RUN);
  end

  always_comb begin
    a_sl = a_reg[cnt_reg*SLICE +: SLICE];
    b_sl = b_reg[cnt_reg*SLICE +: SLICE];
  end

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry_reg),
    .sum   (sum_sl),
    .cout  (cout_sl),
    .c_msb (cmsb_sl)
  );

  // On the last slice the adder outputs carry the MSB carries, so V comes straight from them.
  always_comb begin
    acc_next = acc_reg;
    acc_next[cnt_reg*SLICE +: SLICE] = sum_sl;
    v_final  = cout_sl ^ cmsb_sl;
    res_next = acc_next;
`ifdef ADDSUB_SERIAL_SAT_EN
    if (v_final)
      res_next = a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      a_msb_reg <= 1'b0;
      done_reg  <= 1'b0;
      flags_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_reg     <= A;
        b_reg     <= (op == OP_SUB) ? ~B : B;
        carry_reg <= use_cin ? cin : op;
        a_msb_reg <= A[WIDTH-1];
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
        acc_reg   <= acc_next;
        carry_reg <= cout_sl;
        if (last) begin
          res_reg           <= res_next;
          flags_reg[FLAG_Z] <= (res_next == '0);
          flags_reg[FLAG_N] <= res_next[WIDTH-1];
          flags_reg[FLAG_C] <= cout_sl;
          flags_reg[FLAG_V] <= v_final;
          done_reg          <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign res  = res_reg;
  assign Z    = flags_reg[FLAG_Z];
  assign N    = flags_reg[FLAG_N];
  assign C    = flags_reg[FLAG_C];
  assign V    = flags_reg[FLAG_V];

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial (WIDTH=16, SLICE=4): directed table, handshake corners, random ops.
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst, start, op, use_cin, cin;
  logic [15:0] A, B, res;
  logic        busy, done, Z, N, C, V;

  int checks   = 0;
  int failures = 0;

  addsub_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .use_cin(use_cin), .cin(cin),
    .A(A), .B(B), .busy(busy), .done(done), .res(res), .Z(Z), .N(N), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic        uc;
    logic        ci;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    logic [3:0]  exp_zncv;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Caller is at a negedge; returns just after the accepting edge.
  task automatic issue(input logic o, input logic u, input logic c, input logic [15:0] a, input logic [15:0] b);
    op = o; use_cin = u; cin = c; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output bit ok);
    lat = 0; bcnt = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
    end
  endtask

  // Reference: whole-word arithmetic, signed range test for overflow.
  function automatic logic [19:0] model(input logic o, input logic u, input logic ci,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bp, r;
    logic [16:0] full;
    int          c0, s;
    logic        v;
    bp   = o ? ~b : b;
    c0   = u ? int'(ci) : int'(o);
    full = {1'b0, a} + {1'b0, bp} + 17'(c0);
    s    = int'($signed(a)) + int'($signed(bp)) + c0;
    v    = (s > 32767) || (s < -32768);
    r    = full[15:0];
`ifdef ADDSUB_SERIAL_SAT_EN
    if (v) r = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {(r == 16'h0000), r[15], full[16], v, r};
  endfunction

  task automatic run_op(input string name, input logic o, input logic u, input logic c,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [3:0] ef);
    int lat, bcnt;
    bit ok;
    issue(o, u, c, a, b);
    wait_done(lat, bcnt, ok);
    check({name, "_done"}, 32'(ok), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_busy_cycles"}, 32'(bcnt), 32'd4);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    check({name, "_res"}, 32'(res), 32'(er));
    check({name, "_zncv"}, 32'({Z, N, C, V}), 32'(ef));
    $display("%s op=%0d uc=%0d cin=%0d A=%h B=%h res=%h ZNCV=%b", name, o, u, c, a, b, res, {Z, N, C, V});
  endtask

  initial begin
    int lat, bcnt, ndone;
    bit ok;
    logic [15:0] held;
    logic [19:0] m;
    logic        ro, ru, rc;
    logic [15:0] ra, rb;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0002, 4'b0010};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 16'h0000, 4'b1010};
`ifdef ADDSUB_SERIAL_SAT_EN
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h8000, 4'b0111};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 4'b0111};
`else
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b1011};
`endif
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0003, 16'h0001, 4'b0010};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010};

    rst = 1'b1; start = 1'b0; op = 1'b0; use_cin = 1'b0; cin = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_res", 32'(res), 32'd0);
    check("reset_zncv", 32'({Z, N, C, V}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].uc, vecs[i].ci,
             vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_zncv);
    end

    // Back-to-back: second start issued in the done cycle.
    @(negedge clk);
    run_op("b2b_first", 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h0003, 4'b0000);
    run_op("b2b_second", 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0030, 4'b0000);

    // start pulsed mid-RUN must be ignored.
    @(negedge clk);
    held = res;
    issue(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0003);
    @(negedge clk);
    check("midrun_res_held", 32'(res), 32'(held));
    op = 1'b0; A = 16'hFFFF; B = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt, ok);
    check("midrun_done", 32'(ok), 32'd1);
    check("midrun_latency", 32'(lat), 32'd3);
    check("midrun_res", 32'(res), 32'h0002);
    check("midrun_zncv", 32'({Z, N, C, V}), 32'b0010);
    $display("midrun_ignore res=%h ZNCV=%b", res, {Z, N, C, V});
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrun_no_extra_done", 32'(ndone), 32'd0);

    // Reset two cycles into RUN discards the operation.
    issue(1'b0, 1'b0, 1'b0, 16'h1234, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_res", 32'(res), 32'd0);
    check("midreset_zncv", 32'({Z, N, C, V}), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midreset_no_done", 32'(ndone), 32'd0);
    $display("midrun_reset busy=%0d res=%h", busy, res);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom); ru = 1'($urandom); rc = 1'($urandom);
      ra = 16'($urandom); rb = 16'($urandom);
      if (i % 5 == 0) rb = ra;
      m = model(ro, ru, rc, ra, rb);
      @(negedge clk);
      run_op($sformatf("rand%0d", i), ro, ru, rc, ra, rb, m[15:0], m[19:16]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
